// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ctrl
//  Purpose  : Two-port arbitrated push/pop sequencer for a small LIFO stack
//             backed by a single-port memory with one-cycle read latency.
//  Revision : 1.0
// ============================================================================
module stack_ctrl #(
   parameter int DW    = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_op,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_done,
   output logic          a_err,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_op,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_done,
   output logic          b_err,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW:0]   sp,
   output logic          empty,
   output logic          full,
   output logic          busy
);

   localparam logic [AW:0] FULL_SP = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_SP  = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RDWAIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [AW:0]   sp_nx, sp_inc, sp_dec;
   logic          sel_b, last_b, op_l, err_f, err_nx;
   logic [DW-1:0] data_l;
   logic          take, take_b;

   assign sp_inc = sp + ONE_SP;
   assign sp_dec = sp - ONE_SP;
   assign empty  = (sp == '0);
   assign full   = (sp == FULL_SP);
   assign busy   = (state != IDLE);

   always_comb begin
      state_nx  = state;
      sp_nx     = sp;
      err_nx    = err_f;
      take      = 1'b0;
      take_b    = 1'b0;
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      a_done    = 1'b0;
      b_done    = 1'b0;
      a_err     = 1'b0;
      b_err     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            // B has priority except directly after a B grant, so A waits at most one B transaction
            if (a_req || b_req) begin
               take     = 1'b1;
               take_b   = b_req && (!a_req || !last_b);
               state_nx = EXEC;
            end
         end
         EXEC: begin
            a_gnt  = !sel_b;
            b_gnt  = sel_b;
            err_nx = 1'b0;
            if (!op_l) begin
               if (!full) begin
                  mem_we    = 1'b1;
                  mem_addr  = sp[AW-1:0];
                  mem_wdata = data_l;
                  sp_nx     = sp_inc;
               end else begin
                  err_nx = 1'b1;
               end
               state_nx = DONE;
            end else if (!empty) begin
               mem_addr = sp_dec[AW-1:0];
               sp_nx    = sp_dec;
               state_nx = RDWAIT;
            end else begin
               err_nx   = 1'b1;
               state_nx = DONE;
            end
         end
         RDWAIT: state_nx = DONE;
         DONE: begin
            a_done   = !sel_b;
            b_done   = sel_b;
            a_err    = !sel_b && err_f;
            b_err    = sel_b && err_f;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sp      <= '0;
         err_f   <= 1'b0;
         sel_b   <= 1'b0;
         last_b  <= 1'b0;
         op_l    <= 1'b0;
         data_l  <= '0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state <= state_nx;
         sp    <= sp_nx;
         err_f <= err_nx;
         if (take) begin
            sel_b  <= take_b;
            last_b <= take_b;
            op_l   <= take_b ? b_op : a_op;
            data_l <= take_b ? b_wdata : a_wdata;
         end
         if (state == RDWAIT) begin
            if (sel_b) b_rdata <= mem_rdata;
            else       a_rdata <= mem_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// Testbench for stack_ctrl: behavioural stack model feeds expectation queues,
// an independent monitor checks grants, memory writes and done responses.
`timescale 1ns/1ps
module tb_stack_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a_req = 0, a_op = 0, b_req = 0, b_op = 0;
   logic [3:0] a_wdata = '0, b_wdata = '0;
   logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
   logic [3:0] a_rdata, b_rdata, mem_wdata;
   logic [3:0] mem_rdata = '0;
   logic [1:0] mem_addr;
   logic       mem_we, empty, full, busy;
   logic [2:0] sp;

   int checks = 0;
   int errors = 0;

   stack_ctrl #(.DW(4), .DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_gnt(a_gnt),
      .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_gnt(b_gnt),
      .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .sp(sp), .empty(empty), .full(full), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [3:0] mem [4];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   typedef struct packed {
      logic       port;
      logic       err;
      logic [3:0] rdata;
      logic [2:0] sp;
   } exp_t;

   exp_t       eq[$];
   logic       gq[$];
   logic [5:0] wq[$];

   logic [3:0] stk[$];
   logic       m_last_b = 1'b0;
   logic [3:0] m_rd[2] = '{4'h0, 4'h0};

   task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: stack as a queue, one served request at a time
   task automatic serve(input logic port, input logic op, input logic [3:0] data, output int lat);
      logic e;
      e   = 1'b0;
      lat = 2;
      if (!op) begin
         if (stk.size() < 4) begin
            wq.push_back({2'(stk.size()), data});
            stk.push_back(data);
         end else e = 1'b1;
      end else begin
         if (stk.size() > 0) begin
            m_rd[port] = stk.pop_back();
            lat = 3;
         end else e = 1'b1;
      end
      gq.push_back(port);
      eq.push_back('{port: port, err: e, rdata: m_rd[port], sp: 3'(stk.size())});
      m_last_b = port;
   endtask

   task automatic round(input logic ra, input logic rb, input logic oa, input logic ob,
                        input logic [3:0] da, input logic [3:0] db);
      int lat_a, lat_b, cyc, n, got, ga, gb, dna, dnb;
      lat_a = 0; lat_b = 0; ga = 0; gb = 0; dna = 0; dnb = 0; got = 0; cyc = 0;
      if (ra && rb) begin
         if (!m_last_b) begin
            serve(1'b1, ob, db, lat_b);
            serve(1'b0, oa, da, lat_a);
         end else begin
            serve(1'b0, oa, da, lat_a);
            serve(1'b1, ob, db, lat_b);
         end
      end else if (ra) serve(1'b0, oa, da, lat_a);
      else             serve(1'b1, ob, db, lat_b);
      n = int'(ra) + int'(rb);
      a_req = ra; a_op = oa; a_wdata = da;
      b_req = rb; b_op = ob; b_wdata = db;
      while (got < n && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (a_gnt) begin a_req = 1'b0; if (ga == 0) ga = cyc; end
         if (b_gnt) begin b_req = 1'b0; if (gb == 0) gb = cyc; end
         if (a_done) begin got++; dna = cyc; end
         if (b_done) begin got++; dnb = cyc; end
      end
      if (got < n) begin
         errors++;
         $display("FAIL round_timeout done_seen=%0d expected=%0d", got, n);
         a_req = 1'b0; b_req = 1'b0;
      end
      if (n == 1) begin
         chk(ra ? ga : gb, 1, "gnt_latency");
         chk(ra ? dna : dnb, ra ? lat_a : lat_b, "done_latency");
      end
      @(negedge clk);
   endtask

   // Monitor: compares every DUT response against the queued expectations
   initial begin : monitor
      exp_t       e;
      logic       g;
      logic [5:0] w;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (a_gnt && b_gnt) chk(2, 1, "double_gnt");
            if (a_gnt || b_gnt) begin
               if (gq.size() == 0) chk(1, 0, "unexpected_gnt");
               else begin g = gq.pop_front(); chk(b_gnt, g, "gnt_port"); end
            end
            if (mem_we) begin
               if (wq.size() == 0) chk(1, 0, "unexpected_mem_we");
               else begin w = wq.pop_front(); chk({mem_addr, mem_wdata}, w, "mem_write"); end
            end
            if (a_done && b_done) chk(2, 1, "double_done");
            if (a_done || b_done) begin
               if (eq.size() == 0) chk(1, 0, "unexpected_done");
               else begin
                  e = eq.pop_front();
                  chk(b_done, e.port, "done_port");
                  chk(e.port ? b_err : a_err, e.err, "done_err");
                  chk(e.port ? b_rdata : a_rdata, e.rdata, "rdata");
                  chk(sp, e.sp, "sp");
                  chk(empty, e.sp == 3'd0, "empty");
                  chk(full, e.sp == 3'd4, "full");
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_we, busy, full}, 0, {tag, "_ctl"});
      chk({mem_addr, mem_wdata}, 0, {tag, "_mem"});
      chk({a_rdata, b_rdata}, 0, {tag, "_rdata"});
      chk(sp, 0, {tag, "_sp"});
      chk(empty, 1, {tag, "_empty"});
   endtask

   initial begin : driver
      logic [1:0] sel;
      int         k;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      round(1, 0, 0, 0, 4'h3, 0);
      round(1, 0, 0, 0, 4'h5, 0);
      round(1, 0, 0, 0, 4'h9, 0);
      round(1, 0, 0, 0, 4'hC, 0);
      round(1, 0, 0, 0, 4'h7, 0);
      for (int i = 0; i < 4; i++) round(1, 0, 1, 0, 4'h0, 0);
      round(1, 0, 1, 0, 4'h0, 0);
      round(1, 1, 0, 0, 4'h1, 4'h2);
      round(1, 1, 0, 0, 4'h1, 4'h2);
      for (int i = 0; i < 4; i++) round(1, 0, 1, 0, 4'h0, 0);
      round(1, 1, 1, 0, 4'h0, 4'hE);

      for (int i = 0; i < 60; i++) begin
         sel = 2'($urandom_range(1, 3));
         round(sel[0], sel[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      end

      // Abort a pop while it waits for memory data
      round(1, 0, 0, 0, 4'hA, 0);
      gq.push_back(1'b0);
      a_req = 1'b1; a_op = 1'b1;
      k = 0;
      while (!a_gnt && k < 10) begin @(negedge clk); k++; end
      a_req = 1'b0;
      chk(a_gnt, 1, "abort_gnt_seen");
      @(negedge clk);
      chk(busy, 1, "abort_busy");
      rst = 1'b0;
      #1;
      check_reset_outputs("abort");
      eq.delete(); wq.delete(); gq.delete(); stk.delete();
      m_rd[0] = 4'h0; m_rd[1] = 4'h0; m_last_b = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      round(1, 0, 0, 0, 4'h6, 0);
      round(0, 1, 0, 1, 0, 4'h0);
      round(1, 0, 1, 0, 4'h0, 0);

      repeat (2) @(negedge clk);
      chk(eq.size() + gq.size() + wq.size(), 0, "queues_drained");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencing controller for the processor's 4-bit LIFO stack.
- Arbitrates push/pop requests from two requesters: port A (core CALL/RET path) and port B (interrupt entry/exit path).
- Owns the stack pointer and full/empty status, and drives a single-port stack memory with one-cycle read latency.
- Turns each accepted request into a fixed-latency memory sequence with a done/error response.

Parameters:
- DW, 4, data width of a stack entry
- DEPTH, 4, number of stack entries
- AW, 2, memory address width (clog2(DEPTH))

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- a_req  input  1  port A request; held until a_gnt
- a_op  input  1  port A operation: 0 = push, 1 = pop
- a_wdata  input  DW  port A push data
- a_gnt  output  1  port A request accepted (1-cycle pulse)
- a_done  output  1  port A transaction complete (1-cycle pulse)
- a_err  output  1  qualifies a_done: overflow or underflow
- a_rdata  output  DW  port A pop result, registered
- b_req, b_op, b_wdata, b_gnt, b_done, b_err, b_rdata  same as port A, for port B
- mem_addr  output  AW  stack memory address
- mem_we  output  1  stack memory write strobe
- mem_wdata  output  DW  stack memory write data
- mem_rdata  input  DW  stack memory read data; valid the cycle after the address is presented with mem_we=0
- sp  output  AW+1  occupied entry count, 0..DEPTH
- empty  output  1  sp == 0
- full  output  1  sp == DEPTH
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, sp=0, empty=1, full=0, busy=0.
  - All gnt/done/err=0, a_rdata=b_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-transaction aborts it: no done pulse, sp returns to 0, no further memory write.
- FSM states: IDLE, EXEC, RDWAIT, DONE.
- IDLE, arbitration on sampled req:
  - Only one port requesting: that port wins.
  - Both requesting: B wins, unless the previous grant went to B, in which case A wins. A therefore waits at most one B transaction.
  - Winner's id, op and wdata are latched; next state is EXEC.
  - No request: stay in IDLE.
- EXEC (1 cycle): gnt of the latched port = 1. Requester may drop req from the next cycle.
  - Legal push (sp < DEPTH): mem_we=1, mem_addr=sp[AW-1:0], mem_wdata=latched data; sp <= sp+1; go to DONE.
  - Legal pop (sp > 0): mem_we=0, mem_addr=sp-1; sp <= sp-1; go to RDWAIT.
  - Push when full, or pop when empty: no memory access, sp unchanged, error flag set; go to DONE.
- RDWAIT (1 cycle): latched port's rdata <= mem_rdata; go to DONE.
- DONE (1 cycle): done of the latched port = 1; err = error flag; go to IDLE.
- Latency from the req-sample edge in IDLE:
  - Push: gnt at +1, done at +2.
  - Pop: gnt at +1, done at +3, rdata valid with done.
  - Minimum gap between transactions is one IDLE cycle.
- rdata holds its value until the next successful pop on that port. An errored pop leaves rdata unchanged.
- Pop does not clear memory. Entries above sp are stale and never read.
- req deasserted before the sampling edge has no effect.
- req is ignored in EXEC/RDWAIT/DONE and re-sampled in the next IDLE.
- empty and full are decoded from registered sp and are valid in every cycle.
- sp never wraps: it saturates by rule, since illegal operations are rejected.

Test Plan:
- Reset, then A pushes 4'h3, 4'h5, 4'h9, 4'hC → each: a_gnt at +1, mem_we with addr 0,1,2,3, a_done at +2 with a_err=0; final sp=4, full=1.
- From full, A pushes 4'h7 → a_done with a_err=1, no mem_we, sp stays 4. Then 4 pops → a_rdata 4'hC, 4'h9, 4'h5, 4'h3, each at done (+3); final sp=0, empty=1.
- Pop on empty → a_err=1 at +2 (no RDWAIT), a_rdata unchanged, sp=0.
- A and B push every cycle from empty (A data 4'h1, B data 4'h2) → grant order B, A, B, A; memory holds 2,1,2,1; no double grant.
- B pushes 4'hE, A pops in the same cycle → B served first, then A pops 4'hE; b_done precedes a_gnt.
- rst=0 during RDWAIT of a pop → all outputs 0 immediately, sp=0, no done pulse; the next push after release writes addr 0.
